rs_alu_pool: RTL and testbench

- Parametrised ALU reservation station holding DEPTH in-flight ALU micro-ops.
- Sits between the allocator and one ALU executor.
- Snoops CDB_CNT result buses to resolve operand tags, then issues the oldest fully-ready entry to the executor through a valid/ready handshake.
- Supports pipeline flush.

---
 rtl/rs_alu_pool_pkg.sv | 22 ++
 rtl/rs_alu_pool_age_pick.sv | 28 ++
 rtl/rs_alu_pool.sv | 231 +++++++++++++++++++++++
 tb/tb_rs_alu_pool.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_pool_pkg.sv
// rtl/rs_alu_pool_pkg.sv - shared constants and CDB slice helpers for reservation stations
//
// Purpose : constants shared by all reservation stations (unlocked tag value,
//           default field widths) plus the CDB_SLICE helper macro that picks
//           bus i out of a flattened per-bus vector.
// Ports   : none (package).
`ifndef RS_ALU_POOL_PKG_SV
`define RS_ALU_POOL_PKG_SV

// Slice bus i (width w) out of a flattened CDB vector.
`define CDB_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package rs_alu_pool_pkg;
    localparam int TAG_UNLOCKED = 0;
    localparam int RS_WORD_W    = 32;
    localparam int RS_ADDR_W    = 32;
    localparam int RS_TAG_W     = 4;
    localparam int RS_OP_W      = 6;
    localparam int RS_REG_W     = 5;
endpackage

`endif

// File: rtl/rs_alu_pool_age_pick.sv
// rtl/rs_alu_pool_age_pick.sv - oldest-ready picker over an age matrix
//
// Purpose : given an N x N age matrix (row i, bit j set means entry i is
//           younger than entry j) and a ready vector, select the oldest
//           ready entry as a one-hot vector.
// Ports   : i_age   N*N  flattened matrix, row i at [i*N +: N]
//           i_ready N    per-entry ready
//           o_sel   N    one-hot oldest ready entry (0 when none)
//           o_any   1    some entry is ready
module rs_age_pick #(
    parameter int N = 4
) (
    input  logic [N*N-1:0] i_age,
    input  logic [N-1:0]   i_ready,
    output logic [N-1:0]   o_sel,
    output logic           o_any
);
    // Ready entries are totally ordered by age, so exactly one ready entry
    // has no older ready entry.
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < N; i++) begin
            o_sel[i] = i_ready[i] && ((i_age[i*N +: N] & i_ready) == '0);
        end
    end

    assign o_any = |i_ready;
endmodule

// File: rtl/rs_alu_pool.sv
// rtl/rs_alu_pool.sv - ALU reservation station with CDB wakeup and age-ordered issue
//
// Purpose : holds DEPTH in-flight ALU ops, resolves operand tags from CDB_CNT
//           result buses (including on the allocation cycle) and issues the
//           oldest ready entry to the executor via valid/ready.
// Ports   : clk, rst (sync, active-high), flush
//           in_valid/in_ready + in_pc, in_op, in_tagx/y, in_datax/y, in_tagw, in_addrw
//           cdb_valid, cdb_tag, cdb_data (flattened, bus i at [i*W +: W])
//           out_valid/out_ready + out_pc, out_op, out_datax/y, out_tagw, out_addrw
//           count (occupied entries)
//           perf_full_cycles, perf_peak (only when RS_ALU_PERF_EN is defined)
module rs_alu_pool
    import rs_alu_pool_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CDB_CNT = 3,
    parameter int TAG_W   = RS_TAG_W,
    parameter int WORD_W  = RS_WORD_W,
    parameter int ADDR_W  = RS_ADDR_W,
    parameter int OP_W    = RS_OP_W,
    parameter int REG_W   = RS_REG_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           in_pc,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_tagx,
    input  logic [TAG_W-1:0]            in_tagy,
    input  logic [WORD_W-1:0]           in_datax,
    input  logic [WORD_W-1:0]           in_datay,
    input  logic [TAG_W-1:0]            in_tagw,
    input  logic [REG_W-1:0]            in_addrw,
    input  logic [CDB_CNT-1:0]          cdb_valid,
    input  logic [CDB_CNT*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_CNT*WORD_W-1:0]   cdb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [OP_W-1:0]             out_op,
    output logic [WORD_W-1:0]           out_datax,
    output logic [WORD_W-1:0]           out_datay,
    output logic [TAG_W-1:0]            out_tagw,
    output logic [REG_W-1:0]            out_addrw,
    output logic [$clog2(DEPTH+1)-1:0]  count
`ifdef RS_ALU_PERF_EN
    ,
    output logic [31:0]                 perf_full_cycles,
    output logic [$clog2(DEPTH+1)-1:0]  perf_peak
`endif
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] TAG_UNL = TAG_W'(TAG_UNLOCKED);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_age [DEPTH];
    logic [ADDR_W-1:0] r_pc [DEPTH];
    logic [OP_W-1:0]   r_op [DEPTH];
    logic [TAG_W-1:0]  r_tagx [DEPTH];
    logic [TAG_W-1:0]  r_tagy [DEPTH];
    logic [WORD_W-1:0] r_datax [DEPTH];
    logic [WORD_W-1:0] r_datay [DEPTH];
    logic [TAG_W-1:0]  r_tagw [DEPTH];
    logic [REG_W-1:0]  r_addrw [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic [DEPTH-1:0]       w_ready;
    logic [DEPTH-1:0]       w_sel;
    logic                   w_any;
    logic [DEPTH*DEPTH-1:0] w_age_flat;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_alloc;
    logic                   w_issue;
    logic [WORD_W:0]        w_snx [DEPTH];
    logic [WORD_W:0]        w_sny [DEPTH];
    logic [WORD_W:0]        w_in_snx;
    logic [WORD_W:0]        w_in_sny;

    // Returns {hit, data}. Scanning from the highest bus down lets the lowest
    // matching bus index win on duplicate tags.
    function automatic logic [WORD_W:0] cdb_snoop(
        input logic [TAG_W-1:0]          t,
        input logic [CDB_CNT-1:0]        v,
        input logic [CDB_CNT*TAG_W-1:0]  tg,
        input logic [CDB_CNT*WORD_W-1:0] d
    );
        logic [WORD_W:0] res;
        res = '0;
        if (t != TAG_UNL) begin
            for (int b = CDB_CNT-1; b >= 0; b--) begin
                if (v[b] && (`CDB_SLICE(tg, b, TAG_W) == t)) begin
                    res = {1'b1, `CDB_SLICE(d, b, WORD_W)};
                end
            end
        end
        return res;
    endfunction

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign w_alloc   = in_valid && in_ready;
    assign out_valid = w_any;
    assign w_issue   = w_any && out_ready;
    assign count     = r_count;

    always_comb begin
        w_free_idx = '0;
        w_age_flat = '0;
        for (int e = DEPTH-1; e >= 0; e--) begin
            if (!r_valid[e]) begin
                w_free_idx = IDX_W'(e);
            end
        end
        for (int e = 0; e < DEPTH; e++) begin
            w_ready[e] = r_valid[e] && (r_tagx[e] == TAG_UNL) && (r_tagy[e] == TAG_UNL);
            w_age_flat[e*DEPTH +: DEPTH] = r_age[e];
            w_snx[e] = cdb_snoop(r_tagx[e], cdb_valid, cdb_tag, cdb_data);
            w_sny[e] = cdb_snoop(r_tagy[e], cdb_valid, cdb_tag, cdb_data);
        end
        w_in_snx = cdb_snoop(in_tagx, cdb_valid, cdb_tag, cdb_data);
        w_in_sny = cdb_snoop(in_tagy, cdb_valid, cdb_tag, cdb_data);
    end

    rs_age_pick #(.N(DEPTH)) u_pick (
        .i_age   (w_age_flat),
        .i_ready (w_ready),
        .o_sel   (w_sel),
        .o_any   (w_any)
    );

    always_comb begin
        out_pc    = '0;
        out_op    = '0;
        out_datax = '0;
        out_datay = '0;
        out_tagw  = '0;
        out_addrw = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_sel[e]) begin
                out_pc    = r_pc[e];
                out_op    = r_op[e];
                out_datax = r_datax[e];
                out_datay = r_datay[e];
                out_tagw  = r_tagw[e];
                out_addrw = r_addrw[e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_age[e]   <= '0;
                r_pc[e]    <= '0;
                r_op[e]    <= '0;
                r_tagx[e]  <= '0;
                r_tagy[e]  <= '0;
                r_datax[e] <= '0;
                r_datay[e] <= '0;
                r_tagw[e]  <= '0;
                r_addrw[e] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_age[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (r_valid[e] && w_snx[e][WORD_W]) begin
                    r_tagx[e]  <= TAG_UNL;
                    r_datax[e] <= w_snx[e][WORD_W-1:0];
                end
                if (r_valid[e] && w_sny[e][WORD_W]) begin
                    r_tagy[e]  <= TAG_UNL;
                    r_datay[e] <= w_sny[e][WORD_W-1:0];
                end
                if (w_issue && w_sel[e]) begin
                    r_valid[e] <= 1'b0;
                end
                // Freed entry is no longer older than anyone: clear its column.
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_issue && w_sel[j]) begin
                        r_age[e][j] <= 1'b0;
                    end
                end
                if (w_alloc && (w_free_idx == IDX_W'(e))) begin
                    r_valid[e] <= 1'b1;
                    r_pc[e]    <= in_pc;
                    r_op[e]    <= in_op;
                    r_tagw[e]  <= in_tagw;
                    r_addrw[e] <= in_addrw;
                    r_tagx[e]  <= w_in_snx[WORD_W] ? TAG_UNL : in_tagx;
                    r_datax[e] <= w_in_snx[WORD_W] ? w_in_snx[WORD_W-1:0] : in_datax;
                    r_tagy[e]  <= w_in_sny[WORD_W] ? TAG_UNL : in_tagy;
                    r_datay[e] <= w_in_sny[WORD_W] ? w_in_sny[WORD_W-1:0] : in_datay;
                    // Youngest: younger than every survivor of this cycle.
                    r_age[e]   <= r_valid & ~(w_issue ? w_sel : '0);
                end
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_issue);
        end
    end

`ifdef RS_ALU_PERF_EN
    logic [31:0]      r_perf_full;
    logic [CNT_W-1:0] r_perf_peak;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full <= '0;
            r_perf_peak <= '0;
        end else begin
            if (in_valid && !in_ready && (r_perf_full != '1)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            if (r_count > r_perf_peak) begin
                r_perf_peak <= r_count;
            end
        end
    end

    assign perf_full_cycles = r_perf_full;
    assign perf_peak        = r_perf_peak;
`endif
endmodule

// File: tb/tb_rs_alu_pool.sv
// tb/tb_rs_alu_pool.sv - scoreboard testbench for rs_alu_pool
module tb_rs_alu_pool;
    localparam int DEPTH = 4, CDB_CNT = 3, TAG_W = 4, WORD_W = 32;
    localparam int ADDR_W = 32, OP_W = 6, REG_W = 5, CNT_W = 3;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [ADDR_W-1:0] in_pc, out_pc;
    logic [OP_W-1:0] in_op, out_op;
    logic [TAG_W-1:0] in_tagx, in_tagy, in_tagw, out_tagw;
    logic [WORD_W-1:0] in_datax, in_datay, out_datax, out_datay;
    logic [REG_W-1:0] in_addrw, out_addrw;
    logic [CDB_CNT-1:0] cdb_valid;
    logic [CDB_CNT*TAG_W-1:0] cdb_tag;
    logic [CDB_CNT*WORD_W-1:0] cdb_data;
    logic [CNT_W-1:0] count;
`ifdef RS_ALU_PERF_EN
    logic [31:0] perf_full_cycles;
    logic [CNT_W-1:0] perf_peak;
`endif

    always #5 clk = ~clk;

    rs_alu_pool dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
        .in_tagx(in_tagx), .in_tagy(in_tagy), .in_datax(in_datax), .in_datay(in_datay),
        .in_tagw(in_tagw), .in_addrw(in_addrw),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_datax(out_datax), .out_datay(out_datay), .out_tagw(out_tagw),
        .out_addrw(out_addrw), .count(count)
`ifdef RS_ALU_PERF_EN
        , .perf_full_cycles(perf_full_cycles), .perf_peak(perf_peak)
`endif
    );

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] dx;
        logic [WORD_W-1:0] dy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // op/tagw/addrw are derived from pc so the scoreboard only stores pc.
    task automatic set_op(input logic [31:0] pc, input logic [3:0] tx, input logic [31:0] dx,
                          input logic [3:0] ty, input logic [31:0] dy);
        in_valid = 1'b1;
        in_pc    = pc;
        in_op    = pc[7:2];
        in_tagw  = pc[5:2];
        in_addrw = pc[6:2];
        in_tagx  = tx;
        in_datax = dx;
        in_tagy  = ty;
        in_datay = dy;
    endtask

    task automatic set_cdb(input int b, input logic [3:0] t, input logic [31:0] d);
        cdb_valid[b] = 1'b1;
        cdb_tag[b*TAG_W +: TAG_W] = t;
        cdb_data[b*WORD_W +: WORD_W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_op = '0; in_tagx = '0; in_tagy = '0; in_datax = '0; in_datay = '0;
        in_tagw = '0; in_addrw = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got count=%0d out_valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        checks++;
        if (out_pc !== 0 || out_datax !== 0 || out_datay !== 0 || out_op !== 0 || out_tagw !== 0 || out_addrw !== 0) begin
            errors++;
            $display("FAIL reset_fields: got pc=%h x=%h y=%h want all 0", out_pc, out_datax, out_datay);
        end
    endtask

    task automatic test_basic();
        set_op(32'h10, 0, 32'd5, 0, 32'd7);
        sb.push_back('{pc: 32'h10, dx: 32'd5, dy: 32'd7});
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (count !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
        out_ready = 1'b1;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_datax !== e.dx || out_datay !== e.dy ||
            out_op !== e.pc[7:2] || out_tagw !== e.pc[5:2] || out_addrw !== e.pc[6:2]) begin
            errors++;
            $display("FAIL basic_issue: got v=%b pc=%h x=%h y=%h want pc=%h x=%h y=%h", out_valid, out_pc, out_datax, out_datay, e.pc, e.dx, e.dy);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (count !== 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: got count=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_wakeup();
        set_op(32'h20, 4'd3, 32'hBAD, 0, 32'd1);
        sb.push_back('{pc: 32'h20, dx: 32'hDEAD, dy: 32'd1});
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL wake_pend1: got v=%b want 0", out_valid); end
        @(negedge clk);
        set_cdb(1, 4'd3, 32'hDEAD);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL wake_pend2: got v=%b want 0", out_valid); end
        @(negedge clk);
        cdb_valid = '0;
        out_ready = 1'b1;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_datax !== e.dx || out_datay !== e.dy) begin
            errors++;
            $display("FAIL wake_issue: got v=%b pc=%h x=%h y=%h want pc=%h x=%h y=%h", out_valid, out_pc, out_datax, out_datay, e.pc, e.dx, e.dy);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (count !== 0) begin errors++; $display("FAIL wake_drain: got %0d want 0", count); end
    endtask

    task automatic test_bypass();
        // Bus 2 duplicates the tag with other data; bus 0 must win.
        set_op(32'h30, 0, 32'd9, 4'd6, 32'hBAD);
        set_cdb(0, 4'd6, 32'd42);
        set_cdb(2, 4'd6, 32'd99);
        sb.push_back('{pc: 32'h30, dx: 32'd9, dy: 32'd42});
        @(negedge clk);
        in_valid = 1'b0;
        cdb_valid = '0;
        out_ready = 1'b1;
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_datax !== e.dx || out_datay !== e.dy) begin
            errors++;
            $display("FAIL bypass_issue: got v=%b pc=%h x=%h y=%h want pc=%h x=%h y=%h", out_valid, out_pc, out_datax, out_datay, e.pc, e.dx, e.dy);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_full_order();
        for (int i = 0; i < 4; i++) begin
            set_op(32'h40 + 32'(4*i), 0, 32'(i), 0, 32'(100+i));
            sb.push_back('{pc: 32'h40 + 32'(4*i), dx: 32'(i), dy: 32'(100+i)});
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 4 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_state: got count=%0d in_ready=%b want 4/0", count, in_ready);
        end
        set_op(32'h80, 0, 32'd77, 0, 32'd77);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (count !== 4) begin errors++; $display("FAIL full_reject: got count=%0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_datax !== e.dx || out_datay !== e.dy) begin
                errors++;
                $display("FAIL full_order%0d: got v=%b pc=%h x=%h y=%h want pc=%h x=%h y=%h", i, out_valid, out_pc, out_datax, out_datay, e.pc, e.dx, e.dy);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_drain: got count=%0d v=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_op(32'h100 + 32'(4*i), 0, 32'(i*3), 0, 32'(i*5));
            sb.push_back('{pc: 32'h100 + 32'(4*i), dx: 32'(i*3), dy: 32'(i*5)});
            @(negedge clk);
            checks++;
            if (count !== 1) begin errors++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_datax !== e.dx || out_datay !== e.dy) begin
                errors++;
                $display("FAIL b2b_issue%0d: got v=%b pc=%h x=%h y=%h want pc=%h x=%h y=%h", i, out_valid, out_pc, out_datax, out_datay, e.pc, e.dx, e.dy);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (count !== 0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", count); end
    endtask

    task automatic test_age_priority();
        set_op(32'h200, 4'd2, 32'hBAD, 0, 32'h11);
        @(negedge clk);
        set_op(32'h204, 0, 32'h33, 0, 32'h44);
        sb.push_back('{pc: 32'h204, dx: 32'h33, dy: 32'h44});
        sb.push_back('{pc: 32'h200, dx: 32'h22, dy: 32'h11});
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_cdb(0, 4'd2, 32'h22);
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== e.pc || out_datax !== e.dx || out_datay !== e.dy) begin
                errors++;
                $display("FAIL age_issue%0d: got v=%b pc=%h x=%h y=%h want pc=%h x=%h y=%h", i, out_valid, out_pc, out_datax, out_datay, e.pc, e.dx, e.dy);
            end
            @(negedge clk);
            cdb_valid = '0;
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 0) begin errors++; $display("FAIL age_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_op(32'h300 + 32'(4*i), 0, 32'(i), 0, 32'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3) begin errors++; $display("FAIL flush_pre: got %0d want 3", count); end
        flush = 1'b1;
        set_op(32'h340, 0, 32'd1, 0, 32'd2);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got count=%0d v=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || count !== 0) begin
            errors++; $display("FAIL flush_discard: got v=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

`ifdef RS_ALU_PERF_EN
    task automatic test_perf();
        checks++;
        if (perf_full_cycles !== 32'd1 || perf_peak !== 3'd4) begin
            errors++; $display("FAIL perf: got full=%0d peak=%0d want 1/4", perf_full_cycles, perf_peak);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full_order();
        test_back_to_back();
        test_age_priority();
        test_flush();
`ifdef RS_ALU_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
